// File: rtl/freq_meter.sv
// Gated frequency counter: counts sig_in rising edges over GATE_CYCLES clocks, latches two BCD
// digits and drives a scanned 2-digit 7-segment display. Optional: FREQ_METER_OVF_DASH_EN.
module freq_meter #(
    parameter int GATE_CYCLES = 27_000_000,
    parameter int SCAN_DIV    = 225_000,
    parameter int CNT_W       = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sig_in,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       valid,
    output logic       overflow,
    output logic [6:0] display,
    output logic [1:0] enable
);

    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]       SEG_DASH  = 7'b0000001;

    logic             sync1, sync2, sig_d, edge_stb;
    logic [CNT_W-1:0] gate_cnt;
    logic             terminal;
    logic [3:0]       w_tens, w_ones;
    logic             w_ovf;
    logic [3:0]       nxt_tens, nxt_ones;
    logic             nxt_ovf;
    logic [CNT_W-1:0] scan_cnt;
    logic             digit_sel;
    logic [3:0]       digit;
    logic [6:0]       seg_nxt;

    // NOTE: every clocked block uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            sig_d    <= 1'b0;
            edge_stb <= 1'b0;
        end else begin
            sync1    <= sig_in;
            sync2    <= sync1;
            sig_d    <= sync2;
            edge_stb <= sync2 & ~sig_d;
        end
    end

    assign terminal = (gate_cnt == GATE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt <= '0;
        end else if (terminal) begin
            gate_cnt <= '0;
        end else begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    // NOTE: each output of this block is defaulted first so no path leaves it unassigned (no latch).
    always_comb begin
        nxt_tens = w_tens;
        nxt_ones = w_ones;
        nxt_ovf  = w_ovf;
        if (edge_stb) begin
            if (w_ones < 4'd9) begin
                nxt_ones = w_ones + 4'd1;
            end else if (w_tens < 4'd9) begin
                nxt_ones = 4'd0;
                nxt_tens = w_tens + 4'd1;
            end else begin
                nxt_ovf = 1'b1;
            end
        end
    end

    // A strobe landing in the terminal cycle is folded into the latched result via nxt_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_tens   <= 4'd0;
            w_ones   <= 4'd0;
            w_ovf    <= 1'b0;
            bcd_tens <= 4'd0;
            bcd_ones <= 4'd0;
            overflow <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= terminal;
            if (terminal) begin
                bcd_tens <= nxt_tens;
                bcd_ones <= nxt_ones;
                overflow <= nxt_ovf;
                w_tens   <= 4'd0;
                w_ones   <= 4'd0;
                w_ovf    <= 1'b0;
            end else begin
                w_tens <= nxt_tens;
                w_ones <= nxt_ones;
                w_ovf  <= nxt_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt  <= '0;
            digit_sel <= 1'b0;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt  <= '0;
            digit_sel <= ~digit_sel;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1111110;
            4'd1:    seg7 = 7'b0110000;
            4'd2:    seg7 = 7'b1101101;
            4'd3:    seg7 = 7'b1111001;
            4'd4:    seg7 = 7'b0110011;
            4'd5:    seg7 = 7'b1011011;
            4'd6:    seg7 = 7'b1011111;
            4'd7:    seg7 = 7'b1110000;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1111011;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    always_comb begin
        digit   = digit_sel ? bcd_tens : bcd_ones;
        seg_nxt = seg7(digit);
`ifdef FREQ_METER_OVF_DASH_EN
        if (overflow) begin
            seg_nxt = SEG_DASH;
        end
`endif
    end

    // display and enable share one register stage so they always switch together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            display <= 7'b1111110;
            enable  <= 2'b10;
        end else begin
            display <= seg_nxt;
            enable  <= digit_sel ? 2'b01 : 2'b10;
        end
    end

`ifndef FREQ_METER_OVF_DASH_EN
    logic unused_dash;
    assign unused_dash = ^SEG_DASH;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Scoreboard bench for freq_meter with GATE_CYCLES=1000, SCAN_DIV=4; expected window results
// are queued as stimulus is driven and compared on each valid pulse.
`timescale 1ns/1ps
module tb_freq_meter;

    localparam int GATE = 1000;
    localparam int SCAN = 4;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sig_in;
    logic [3:0] bcd_tens, bcd_ones;
    logic       valid, overflow;
    logic [6:0] display;
    logic [1:0] enable;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];
    exp_t exp_now;
    logic valid_prev = 1'b0;

    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_9 = 7'b1111011;
`ifdef FREQ_METER_OVF_DASH_EN
    localparam logic [6:0] SEG_OVF = 7'b0000001;
`else
    localparam logic [6:0] SEG_OVF = SEG_9;
`endif

    freq_meter #(.GATE_CYCLES(GATE), .SCAN_DIV(SCAN), .CNT_W(25)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sig_in   (sig_in),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones),
        .valid    (valid),
        .overflow (overflow),
        .display  (display),
        .enable   (enable)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        else n_pass++;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulses(input int n, input int half);
        for (int i = 0; i < n; i++) begin
            sig_in = 1'b1;
            step(half);
            sig_in = 1'b0;
            step(half);
        end
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        for (int i = 1; i <= budget; i++) begin
            step(1);
            if (valid === 1'b1) begin
                cyc = i;
                break;
            end
        end
        if (cyc == 0) check("valid_timeout", 0, 1);
    endtask

    task automatic scan_check(input string tag, input logic [6:0] seg_ones, input logic [6:0] seg_tens);
        logic [1:0] en [16];
        int first;
        for (int i = 0; i < 16; i++) begin
            en[i] = enable;
            if (enable == 2'b10)      check({tag, "_ones_seg"}, display, seg_ones);
            else if (enable == 2'b01) check({tag, "_tens_seg"}, display, seg_tens);
            else                      check({tag, "_enable"}, enable, 2'b10);
            step(1);
        end
        first = -1;
        for (int i = 1; i < 16; i++)
            if (first < 0 && en[i] != en[i-1]) first = i;
        check({tag, "_first_toggle"}, (first >= 1 && first <= SCAN), 1);
        if (first > 0)
            for (int i = first + 1; i < 16; i++)
                check({tag, "_period"}, en[i] != en[i-1], ((i - first) % SCAN) == 0);
    endtask

    // Scoreboard side: every valid pulse pops one expected window result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1) begin
            check("valid_one_cycle", valid_prev, 0);
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", 1, 0);
            end else begin
                exp_now = sb.pop_front();
                check("bcd_tens", bcd_tens, exp_now.tens);
                check("bcd_ones", bcd_ones, exp_now.ones);
                check("overflow", overflow, exp_now.ovf);
            end
        end
        valid_prev = (rst_n === 1'b1) ? valid : 1'b0;
    end

    initial begin
        #400_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst_n  = 1'b0;
        sig_in = 1'b0;
        step(5);
        check("rst_bcd_tens", bcd_tens, 0);
        check("rst_bcd_ones", bcd_ones, 0);
        check("rst_valid", valid, 0);
        check("rst_overflow", overflow, 0);
        check("rst_enable", enable, 2'b10);
        check("rst_display", display, SEG_0);

        // Idle first window: result 00 exactly GATE cycles after release.
        sb.push_back('{4'd0, 4'd0, 1'b0});
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid(GATE + 100, cyc);
        check("first_valid_latency", cyc, GATE);

        sb.push_back('{4'd4, 4'd2, 1'b0});
        pulses(42, 10);
        wait_valid(GATE + 100, cyc);

        sb.push_back('{4'd0, 4'd0, 1'b0});
        step(2);
        scan_check("scan42", SEG_2, SEG_4);
        wait_valid(GATE + 100, cyc);

        // Saturation, then recovery in the following window.
        sb.push_back('{4'd9, 4'd9, 1'b1});
        pulses(105, 4);
        wait_valid(GATE + 100, cyc);
        sb.push_back('{4'd1, 4'd2, 1'b0});
        step(2);
        scan_check("scan_ovf", SEG_OVF, SEG_OVF);
        pulses(12, 10);
        wait_valid(GATE + 100, cyc);

`ifdef FREQ_METER_OVF_DASH_EN
        sb.push_back('{4'd9, 4'd9, 1'b1});
        pulses(150, 3);
        wait_valid(GATE + 100, cyc);
        sb.push_back('{4'd0, 4'd0, 1'b0});
        step(2);
        scan_check("scan_dash", 7'b0000001, 7'b0000001);
        wait_valid(GATE + 100, cyc);
`endif

        // Partial window discarded by a mid-window reset.
        pulses(20, 10);
        rst_n = 1'b0;
        step(3);
        check("midrst_bcd_tens", bcd_tens, 0);
        check("midrst_bcd_ones", bcd_ones, 0);
        check("midrst_valid", valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{4'd0, 4'd7, 1'b0});
        step(1);
        pulses(7, 10);
        wait_valid(GATE + 100, cyc);
        check("restart_latency", 1 + 140 + cyc, GATE);

        // Level held high: one edge in the first window, none in the second.
        sb.push_back('{4'd0, 4'd1, 1'b0});
        sig_in = 1'b1;
        wait_valid(GATE + 100, cyc);
        sb.push_back('{4'd0, 4'd0, 1'b0});
        wait_valid(GATE + 100, cyc);

        // Edge 3 cycles before terminal lands in this window.
        sb.push_back('{4'd0, 4'd1, 1'b0});
        step(5);
        sig_in = 1'b0;
        step(GATE - 4 - 5);
        sig_in = 1'b1;
        wait_valid(GATE + 100, cyc);

        // Edge 2 cycles before terminal spills into the next window.
        sb.push_back('{4'd0, 4'd0, 1'b0});
        step(5);
        sig_in = 1'b0;
        step(GATE - 3 - 5);
        sig_in = 1'b1;
        wait_valid(GATE + 100, cyc);
        sb.push_back('{4'd0, 4'd1, 1'b0});
        step(5);
        sig_in = 1'b0;
        wait_valid(GATE + 100, cyc);

        step(5);
        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
